// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: CPU retire-trace capture buffer.
// The block is armed, waits for a trigger PC (or the first valid sample), and records
// {pc, data} samples until the buffer fills or capture is stopped.
// The captured entries are then read out in write order through a valid/ready port.
`timescale 1ns/1ps

module cpu_trace_capture #(
   parameter int SIZE  = 8,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    arm,
   input  logic                    stop,
   input  logic                    trig_en,
   input  logic [SIZE-1:0]         trig_pc,
   input  logic                    trace_valid,
   input  logic [SIZE-1:0]         trace_pc,
   input  logic [SIZE-1:0]         trace_data,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [SIZE-1:0]         rd_pc,
   output logic [SIZE-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic [1:0]              state,
   output logic                    done,
   output logic                    overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("cpu_trace_capture: DEPTH must be a power of two and at least 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } st_t;

   st_t               st_q, st_d;
   logic [PW-1:0]     wptr_q, rptr_q;
   logic [CW-1:0]     cnt_q;
   logic              ovf_q;
   logic [2*SIZE-1:0] mem [DEPTH];

   logic trig_hit, wr_en, rd_en, ovf_set;

   // A sample qualifies as the trigger when valid and, if enabled, the PC matches.
   // arm and rst override everything, so they suppress any concurrent write or read.
   always_comb begin
      trig_hit = trace_valid && (!trig_en || (trace_pc == trig_pc));
      wr_en    = !rst && !arm &&
                 (((st_q == ST_ARMED) && !stop && trig_hit) ||
                  ((st_q == ST_CAPTURE) && trace_valid));
      rd_en    = !rst && !arm && rd_valid && rd_ready;
      ovf_set  = !rst && !arm && (st_q == ST_DONE) && trace_valid && (cnt_q == CNT_FULL);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) st_q <= ST_IDLE;
      else     st_q <= st_d;
   end

   // Next-state logic; arm restarts the session from any state.
   always_comb begin
      st_d = st_q;
      if (arm) begin
         st_d = ST_ARMED;
      end else begin
         case (st_q)
            ST_IDLE:    st_d = ST_IDLE;
            ST_ARMED:   if (stop) st_d = ST_DONE;
                        else if (trig_hit) st_d = ST_CAPTURE;
            ST_CAPTURE: if (stop || (trace_valid && (cnt_q == CNT_LAST))) st_d = ST_DONE;
            ST_DONE:    if ((cnt_q == '0) || (rd_en && (cnt_q == CNT_ONE))) st_d = ST_IDLE;
            default:    st_d = ST_IDLE;
         endcase
      end
   end

   // Output decode and read-head presentation.
   always_comb begin
      state              = st_q;
      done               = (st_q == ST_DONE);
      rd_valid           = (st_q == ST_DONE) && (cnt_q != '0);
      {rd_pc, rd_data}   = mem[rptr_q];
      count              = cnt_q;
      overflow           = ovf_q;
   end

   // Pointer, count and sticky overflow bookkeeping. Writes and reads never coincide
   // because writes happen only while armed/capturing and reads only in DONE.
   always_ff @(posedge clk) begin
      if (rst || arm) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (wr_en) begin
            wptr_q <= wptr_q + PTR_ONE;
            cnt_q  <= cnt_q + CNT_ONE;
         end else if (rd_en) begin
            rptr_q <= rptr_q + PTR_ONE;
            cnt_q  <= cnt_q - CNT_ONE;
         end
         if (ovf_set) ovf_q <= 1'b1;
      end
   end

   // Trace storage; contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr_q] <= {trace_pc, trace_data};
   end

endmodule

// File: tb/tb_cpu_trace_capture.sv
// tb_cpu_trace_capture: directed scenarios plus a randomized phase, all checked
// every cycle against a queue-based reference model of the capture buffer.
`timescale 1ns/1ps

module tb_cpu_trace_capture;

   localparam int SIZE  = 8;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            arm = 1'b0;
   logic            stop = 1'b0;
   logic            trig_en = 1'b0;
   logic [SIZE-1:0] trig_pc = '0;
   logic            trace_valid = 1'b0;
   logic [SIZE-1:0] trace_pc = '0;
   logic [SIZE-1:0] trace_data = '0;
   logic            rd_ready = 1'b0;
   logic            rd_valid;
   logic [SIZE-1:0] rd_pc, rd_data;
   logic [$clog2(DEPTH):0] count;
   logic [1:0]      state;
   logic            done;
   logic            overflow;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: session phase, captured entries in order, sticky overflow.
   int                m_st  = 0;
   logic [2*SIZE-1:0] m_q[$];
   bit                m_ovf = 1'b0;

   cpu_trace_capture #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .arm(arm), .stop(stop), .trig_en(trig_en),
      .trig_pc(trig_pc), .trace_valid(trace_valid), .trace_pc(trace_pc),
      .trace_data(trace_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_pc(rd_pc), .rd_data(rd_data), .count(count), .state(state),
      .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance the model with the inputs currently applied.
   task automatic model_update();
      if (rst) begin
         m_st = 0; m_q.delete(); m_ovf = 1'b0;
      end else if (arm) begin
         m_st = 1; m_q.delete(); m_ovf = 1'b0;
      end else begin
         case (m_st)
            1: if (stop) m_st = 3;
               else if (trace_valid && (!trig_en || trace_pc == trig_pc)) begin
                  m_q.push_back({trace_pc, trace_data});
                  m_st = 2;
               end
            2: begin
               if (trace_valid) m_q.push_back({trace_pc, trace_data});
               if (m_q.size() == DEPTH || stop) m_st = 3;
            end
            3: if (m_q.size() == 0) m_st = 0;
               else begin
                  if (trace_valid && m_q.size() == DEPTH) m_ovf = 1'b1;
                  if (rd_ready) void'(m_q.pop_front());
                  if (m_q.size() == 0) m_st = 0;
               end
            default: ;
         endcase
      end
   endtask

   task automatic check_outputs();
      chk("state", 32'(state), 32'(m_st));
      chk("count", 32'(count), 32'(m_q.size()));
      chk("done", 32'(done), 32'(m_st == 3));
      chk("rd_valid", 32'(rd_valid), 32'(m_st == 3 && m_q.size() != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_st == 3 && m_q.size() != 0) begin
         chk("rd_pc", 32'(rd_pc), 32'(m_q[0][2*SIZE-1:SIZE]));
         chk("rd_data", 32'(rd_data), 32'(m_q[0][SIZE-1:0]));
      end
   endtask

   // One clock: model sees the applied inputs, DUT outputs checked 1ns after the edge.
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic clear_inputs();
      rst = 0; arm = 0; stop = 0; trace_valid = 0; rd_ready = 0;
   endtask

   task automatic do_arm();
      clear_inputs(); arm = 1; step(); arm = 0;
   endtask

   task automatic sample(input logic [SIZE-1:0] pc);
      trace_valid = 1; trace_pc = pc; trace_data = SIZE'($urandom);
      step();
      trace_valid = 0;
   endtask

   task automatic drain();
      rd_ready = 1;
      for (int i = 0; i < DEPTH + 2 && state == 2'd3; i++) step();
      rd_ready = 0;
   endtask

   initial begin
      int reads;
      // Reset
      step(); step();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rdvalid", 32'(rd_valid), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      clear_inputs(); step();

      // Inputs other than arm ignored in IDLE
      trace_valid = 1; stop = 1; rd_ready = 1; step(); clear_inputs();
      chk("idle_ignore", 32'(state), 32'd0);

      // Free-run capture of pc 0..15 and ordered readout
      trig_en = 0; do_arm();
      chk("fr_armed", 32'(state), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         sample(SIZE'(i));
         if (i == 0) chk("fr_cap", 32'(state), 32'd2);
      end
      chk("fr_done", 32'(state), 32'd3);
      chk("fr_count", 32'(count), 32'(DEPTH));
      rd_ready = 1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("fr_rdpc", 32'(rd_pc), 32'(i));
         step();
      end
      rd_ready = 0;
      chk("fr_idle", 32'(state), 32'd0);

      // Trigger on pc 0x05 within a 0x01..0x0A stream
      trig_en = 1; trig_pc = 8'h05; do_arm();
      for (int i = 1; i <= 10; i++) sample(SIZE'(i));
      chk("trg_count", 32'(count), 32'd6);
      chk("trg_state", 32'(state), 32'd2);
      stop = 1; step(); stop = 0;
      chk("trg_first", 32'(rd_pc), 32'h05);
      drain();
      chk("trg_idle", 32'(state), 32'd0);

      // Early stop after 3 samples, read with rd_ready toggling
      trig_en = 0; do_arm();
      for (int i = 0; i < 3; i++) sample(SIZE'(8'h40 + i));
      stop = 1; step(); stop = 0;
      chk("es_state", 32'(state), 32'd3);
      chk("es_count", 32'(count), 32'd3);
      reads = 0;
      for (int c = 0; c < 12; c++) begin
         rd_ready = c[0];
         if (rd_valid && rd_ready) reads++;
         step();
      end
      rd_ready = 0;
      chk("es_reads", 32'(reads), 32'd3);
      chk("es_idle", 32'(state), 32'd0);

      // Overflow: full buffer plus a sample in DONE, then arm clears it
      do_arm();
      for (int i = 0; i < DEPTH; i++) sample(SIZE'($urandom));
      sample(8'hEE);
      chk("ov_flag", 32'(overflow), 32'd1);
      chk("ov_count", 32'(count), 32'(DEPTH));
      do_arm();
      chk("ov_clr", 32'(overflow), 32'd0);
      chk("ov_cnt0", 32'(count), 32'd0);
      chk("ov_armed", 32'(state), 32'd1);

      // Reset during capture with 7 entries held
      for (int i = 0; i < 7; i++) sample(SIZE'(i));
      chk("rm_count", 32'(count), 32'd7);
      chk("rm_state", 32'(state), 32'd2);
      rst = 1; step(); rst = 0;
      chk("rm_idle", 32'(state), 32'd0);
      chk("rm_cnt0", 32'(count), 32'd0);
      chk("rm_rdv", 32'(rd_valid), 32'd0);
      for (int i = 0; i < 3; i++) sample(SIZE'(i));
      chk("rm_nowr", 32'(count), 32'd0);

      // arm together with stop acts as arm
      arm = 1; stop = 1; step(); clear_inputs();
      chk("armstop", 32'(state), 32'd1);

      // Randomized phase
      for (int c = 0; c < 4000; c++) begin
         rst         = ($urandom_range(0, 299) == 0);
         arm         = ($urandom_range(0, 59) == 0);
         stop        = ($urandom_range(0, 39) == 0);
         trace_valid = 1'($urandom_range(0, 1));
         trace_pc    = SIZE'($urandom_range(0, 7));
         trace_data  = SIZE'($urandom);
         rd_ready    = 1'($urandom_range(0, 1));
         if (arm) begin
            trig_en = 1'($urandom_range(0, 1));
            trig_pc = SIZE'($urandom_range(0, 7));
         end
         step();
      end
      clear_inputs();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_trace_capture.md
CPU_TRACE_CAPTURE -- requirements
Module: cpu_trace_capture

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, giving the trace PC and data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving buffer entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port arm  input  1  single-cycle pulse that clears the buffer and starts a capture session.
REQ-006 The block SHALL have port stop  input  1  pulse that ends capture early.
REQ-007 The block SHALL have port trig_en  input  1  when 1, capture waits for trig_pc; when 0, it starts on the first valid sample.
REQ-008 The block SHALL have port trig_pc  input  SIZE  PC value that triggers capture.
REQ-009 The block SHALL have port trace_valid  input  1  marks a CPU retire sample this cycle.
REQ-010 The block SHALL have port trace_pc  input  SIZE  PC of the retired instruction.
REQ-011 The block SHALL have port trace_data  input  SIZE  result or accumulator value of the retired instruction.
REQ-012 The block SHALL have port rd_valid  output  1  a buffered entry is presented.
REQ-013 The block SHALL have port rd_ready  input  1  reader accepts the entry.
REQ-014 The block SHALL have port rd_pc, rd_data  output  SIZE each  entry at the read head.
REQ-015 The block SHALL have port count  output  $clog2(DEPTH)+1  number of entries held.
REQ-016 The block SHALL have port state  output  2  encodes IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-017 The block SHALL have port done  output  1  high in DONE.
REQ-018 The block SHALL have port overflow  output  1  sticky; a sample arrived with the buffer full in DONE.

Function
REQ-019 The FSM SHALL go from IDLE to ARMED on arm; other inputs SHALL be ignored in IDLE.
REQ-020 In ARMED, a sample SHALL trigger when trace_valid && (!trig_en || trace_pc==trig_pc); that sample SHALL be written as entry 0, and the FSM SHALL go to CAPTURE on the same edge.
REQ-021 In CAPTURE, each trace_valid SHALL write {trace_pc, trace_data} at the write pointer and increment both the write pointer and count.
REQ-022 CAPTURE SHALL go to DONE on the edge on which count becomes DEPTH, or on stop; a write on the stop cycle SHALL still be taken if space remains.
REQ-023 A stop in ARMED SHALL go to DONE with count=0; DONE with count 0 SHALL go to IDLE on the next edge.
REQ-024 rd_valid SHALL equal (state==DONE && count!=0); rd_pc and rd_data SHALL be the oldest unread entry, driven combinationally from the read pointer.
REQ-025 A read SHALL occur when rd_valid && rd_ready, advancing the read pointer and decrementing count; entries SHALL be read in write order.
REQ-026 The read that takes count from 1 to 0 SHALL move the FSM to IDLE on that edge; done SHALL deassert.
REQ-027 rd_ready SHALL be ignored while rd_valid=0; no writes SHALL occur in DONE or IDLE.
REQ-028 trace_valid in DONE while count==DEPTH SHALL set overflow; the sample SHALL be dropped.
REQ-029 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-030 arm in any state other than IDLE SHALL restart the session: pointers, count and overflow SHALL clear, the FSM SHALL go to ARMED, and any concurrent sample or read SHALL be discarded.
REQ-031 arm and stop asserted together SHALL be treated as arm.

Reset
REQ-032 While rst=1 at a clock edge, the FSM SHALL go to IDLE, the pointers and count SHALL become 0, and overflow, done and rd_valid SHALL become 0; rst SHALL take priority over all inputs.
REQ-033 Buffer contents SHALL NOT require reset; rd_pc and rd_data are don't-care while rd_valid=0.
REQ-034 Assertion of rst mid-capture or mid-readout SHALL abandon the session with no further writes or reads.

Verification
REQ-035 The bench SHALL cover free-run: trig_en=0, arm, then 16 consecutive samples with pc=0..15 -> state CAPTURE after the first, DONE after the 16th, count=16, and a readout yielding pc 0..15 in order, after which the FSM returns to IDLE.
REQ-036 The bench SHALL cover trigger: trig_en=1, trig_pc=0x05, and samples pc=0x01..0x0A -> first entry pc=0x05 and count=6 after the stream.
REQ-037 The bench SHALL cover early stop: after 3 captured samples, stop -> DONE with count=3; reading with rd_ready toggling every other cycle -> exactly 3 entries, then IDLE.
REQ-038 The bench SHALL cover overflow: a full buffer plus trace_valid in DONE -> overflow=1 and count stays 16; a subsequent arm -> overflow=0, count=0, state ARMED.
REQ-039 The bench SHALL cover reset mid-operation: rst asserted during CAPTURE with count=7 -> the next cycle has state IDLE, count 0 and rd_valid 0, and trace_valid then produces no writes.
